// File: rtl/udcnt_pkg.sv
// Shared constants for the programmable up/down counter.
// Holds the run-control state encoding, direction and bound-mode values.
package udcnt_pkg;

  // Run-control FSM encoding
  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] RUN    = 2'b01;
  localparam logic [1:0] PAUSED = 2'b10;

  // updown input values
  localparam logic UP   = 1'b0;
  localparam logic DOWN = 1'b1;

  // sat_mode input values
  localparam logic WRAP = 1'b0;
  localparam logic SAT  = 1'b1;

endpackage

// File: rtl/udcnt_prescaler.sv
// Integer prescaler for prog_udcounter: counts 0..DIV-1 while run is high,
// holds while run is low, clears on clr. tick flags the last phase.
// Ports: clk, reset (sync, active-high), run, clr -> tick (combinational).
module udcnt_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned    PW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]  LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick = run && (pre_q == LAST);

  // Next phase: clear wins, otherwise advance and roll over on tick
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (run) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/prog_udcounter.sv
// Parametrised up/down counter with IDLE/RUN/PAUSED run control,
// rising-edge synchronous load, wrap/saturate bounds, terminal-count pulse
// and an integer prescaler (udcnt_prescaler).
// Ports: clk, reset (sync, active-high), start, stop, load, load_val,
//        updown, sat_mode, cmp_val -> count, tc, running, cmp_match.
// Build option: define UDCNT_CMP_EN to build the cmp_val compare pulse;
// without it cmp_match is constant 0.
module prog_udcounter
  import udcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             updown,
  input  logic             sat_mode,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running,
  output logic             cmp_match
);

  localparam logic [WIDTH-1:0] MAXV = '1;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [1:0]       state_q, state_d;
  logic             load_q;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             running_q, running_d;
  logic             cmp_q, cmp_d;

  logic load_fire;
  logic run_c;
  logic clr_c;
  logic tick;

  assign load_fire = load && !load_q;
  // stop gates the prescaler directly so the count freezes at the edge
  // that first samples stop, not one edge later
  assign run_c     = (state_q == RUN) && !stop;
  assign clr_c     = load_fire || (state_q == IDLE);

  udcnt_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (run_c),
    .clr   (clr_c),
    .tick  (tick)
  );

  // Next state, next count and registered output pulses
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    tc_d      = 1'b0;
    cmp_d     = 1'b0;

    case (state_q)
      IDLE:    if (start && !stop) state_d = RUN;
      RUN:     if (stop) state_d = PAUSED;
               else if (!start) state_d = IDLE;
      PAUSED:  if (!stop) state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if (load_fire) begin
      count_d = load_val;
    end else if (tick) begin
      if (updown == DOWN) begin
        if (count_q == '0) begin
          if (sat_mode == WRAP) begin
            count_d = MAXV;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q - ONE;
          tc_d    = (sat_mode == SAT) && (count_q == ONE);
        end
      end else begin
        if (count_q == MAXV) begin
          if (sat_mode == WRAP) begin
            count_d = '0;
            tc_d    = 1'b1;
          end
        end else begin
          count_d = count_q + ONE;
          tc_d    = (sat_mode == SAT) && (count_q == (MAXV - ONE));
        end
      end
    end

`ifdef UDCNT_CMP_EN
    // Pulse only when a load or a real step lands on cmp_val
    cmp_d = (load_fire || (count_d != count_q)) && (count_d == cmp_val);
`else
    // No comparator; the reference keeps the port connected and folds to 0
    cmp_d = 1'b0 & (^cmp_val);
`endif

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      load_q    <= 1'b0;
      count_q   <= '0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      cmp_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load;
      count_q   <= count_d;
      tc_q      <= tc_d;
      running_q <= running_d;
      cmp_q     <= cmp_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign running   = running_q;
  assign cmp_match = cmp_q;

endmodule

// File: tb/tb_prog_udcounter.sv
// Bench for prog_udcounter: two instances (DIV=1 and DIV=4) share stimulus;
// a behavioural model tracks each and every output is compared each cycle,
// plus directed constant checks for the listed scenarios.
module tb_prog_udcounter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stop, load, updown, sat_mode;
  logic [7:0] load_val, cmp_val;
  logic [7:0] cnt_a, cnt_b;
  logic       tc_a, tc_b, run_a, run_b, cm_a, cm_b;

  int total = 0;
  int bad   = 0;

  prog_udcounter #(.WIDTH(8), .DIV(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .updown(updown), .sat_mode(sat_mode),
    .cmp_val(cmp_val), .count(cnt_a), .tc(tc_a), .running(run_a),
    .cmp_match(cm_a)
  );

  prog_udcounter #(.WIDTH(8), .DIV(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load),
    .load_val(load_val), .updown(updown), .sat_mode(sat_mode),
    .cmp_val(cmp_val), .count(cnt_b), .tc(tc_b), .running(run_b),
    .cmp_match(cm_b)
  );

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2;

  typedef struct {
    int st;
    int pre;
    int cnt;
    bit tc;
    bit cm;
    bit lq;
  } mdl_t;

  mdl_t ma, mb;

  // One clock edge of the reference behaviour, from the inputs seen at it
  function automatic mdl_t mstep(mdl_t m, int div);
    mdl_t n;
    bit   fire, tick;
    int   raw;
    n    = m;
    n.tc = 0;
    n.cm = 0;
    n.lq = load;
    if (reset) begin
      n = '{default: 0};
      return n;
    end
    fire = load && !m.lq;
    tick = (m.st == M_RUN) && !stop && (m.pre == div - 1);

    if (m.st == M_IDLE)      n.st = (start && !stop) ? M_RUN : M_IDLE;
    else if (m.st == M_RUN)  n.st = stop ? M_PAUSED : (start ? M_RUN : M_IDLE);
    else                     n.st = stop ? M_PAUSED : (start ? M_RUN : M_IDLE);

    if (fire || m.st == M_IDLE)         n.pre = 0;
    else if (m.st == M_RUN && !stop)    n.pre = (m.pre + 1) % div;

    if (fire) begin
      n.cnt = int'(load_val);
    end else if (tick) begin
      raw = m.cnt + (updown ? -1 : 1);
      if (raw < 0 || raw > 255) begin
        if (!sat_mode) begin
          n.cnt = (raw + 256) % 256;
          n.tc  = 1;
        end
      end else begin
        n.cnt = raw;
        n.tc  = sat_mode && (raw == 0 || raw == 255);
      end
    end
`ifdef UDCNT_CMP_EN
    n.cm = fire ? (load_val == cmp_val)
                : (tick && n.cnt != m.cnt && n.cnt == int'(cmp_val));
`endif
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, step both models, compare all outputs mid-cycle
  task automatic cycle();
    @(posedge clk);
    ma = mstep(ma, 1);
    mb = mstep(mb, 4);
    @(negedge clk);
    chk("a_count",   32'(cnt_a), 32'(ma.cnt));
    chk("a_tc",      32'(tc_a),  32'(ma.tc));
    chk("a_running", 32'(run_a), 32'(ma.st == M_RUN));
    chk("a_cmp",     32'(cm_a),  32'(ma.cm));
    chk("b_count",   32'(cnt_b), 32'(mb.cnt));
    chk("b_tc",      32'(tc_b),  32'(mb.tc));
    chk("b_running", 32'(run_b), 32'(mb.st == M_RUN));
    chk("b_cmp",     32'(cm_b),  32'(mb.cm));
  endtask

  initial begin
    logic exp_cmp;
    ma = '{default: 0};
    mb = '{default: 0};
    reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0;
    load_val = 8'h00; updown = 1'b0; sat_mode = 1'b0; cmp_val = 8'd3;
    @(negedge clk);

    // Reset state
    cycle(); cycle();
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_running", 32'(run_a), 32'd0);
    chk("rst_tc", 32'(tc_a), 32'd0);

    // Count up from 0: running after the start edge, 10 after 10 more edges
    reset = 1'b0; start = 1'b1;
    repeat (11) cycle();
    chk("up10_count", 32'(cnt_a), 32'd10);
    chk("up10_running", 32'(run_a), 32'd1);

    // Wrap at the top: FE, FF, 00 with tc only at 00
    load_val = 8'hFE; load = 1'b1; cycle(); load = 1'b0;
    chk("ld_fe", 32'(cnt_a), 32'hFE);
    cycle();
    chk("wrap_ff", 32'(cnt_a), 32'hFF);
    chk("wrap_ff_tc", 32'(tc_a), 32'd0);
    cycle();
    chk("wrap_00", 32'(cnt_a), 32'h00);
    chk("wrap_00_tc", 32'(tc_a), 32'd1);
    cycle();
    chk("wrap_01_tc", 32'(tc_a), 32'd0);

    // Saturate at the bottom: 01, 00, 00, 00 with a single tc
    load_val = 8'h02; updown = 1'b1; sat_mode = 1'b1; load = 1'b1; cycle(); load = 1'b0;
    chk("ld_02", 32'(cnt_a), 32'h02);
    cycle();
    chk("sat_01", 32'(cnt_a), 32'h01);
    cycle();
    chk("sat_00a", 32'(cnt_a), 32'h00);
    chk("sat_00a_tc", 32'(tc_a), 32'd1);
    cycle();
    chk("sat_00b", 32'(cnt_a), 32'h00);
    chk("sat_00b_tc", 32'(tc_a), 32'd0);
    cycle();
    chk("sat_00c_tc", 32'(tc_a), 32'd0);

    // Pause at 20, release gives 21 on the second edge
    updown = 1'b0; sat_mode = 1'b0; load_val = 8'd20; load = 1'b1; cycle(); load = 1'b0;
    chk("ld_20", 32'(cnt_a), 32'd20);
    stop = 1'b1;
    repeat (10) cycle();
    chk("stop_hold", 32'(cnt_a), 32'd20);
    chk("stop_running", 32'(run_a), 32'd0);
    stop = 1'b0;
    cycle();
    chk("rel_edge1", 32'(cnt_a), 32'd20);
    cycle();
    chk("rel_edge2", 32'(cnt_a), 32'd21);

    // Held load gives exactly one load
    load_val = 8'h40; load = 1'b1;
    cycle();
    chk("hold_ld_40", 32'(cnt_a), 32'h40);
    repeat (4) cycle();
    chk("hold_ld_44", 32'(cnt_a), 32'h44);
    load = 1'b0;

    // Reset mid-run
    reset = 1'b1;
    cycle();
    chk("midrst_count", 32'(cnt_a), 32'd0);
    chk("midrst_running", 32'(run_a), 32'd0);
    reset = 1'b0;

    // DIV=4 instance reaches 3 after start edge + 12; compare pulse there
    repeat (13) cycle();
    chk("div4_count3", 32'(cnt_b), 32'd3);
`ifdef UDCNT_CMP_EN
    exp_cmp = 1'b1;
`else
    exp_cmp = 1'b0;
`endif
    chk("div4_cmp_pulse", 32'(cm_b), 32'(exp_cmp));
    cycle();
    chk("div4_cmp_after", 32'(cm_b), 32'd0);
    chk("div4_count_hold", 32'(cnt_b), 32'd3);

    // Randomised traffic against the model
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      start    = ($urandom_range(0, 9) != 0);
      stop     = ($urandom_range(0, 9) == 0);
      load     = ($urandom_range(0, 14) == 0) ? 1'b1 : (load && ($urandom_range(0, 1) == 1));
      case ($urandom_range(0, 3))
        0:       load_val = 8'hFE;
        1:       load_val = 8'h01;
        default: load_val = 8'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) updown   = ~updown;
      if ($urandom_range(0, 29) == 0) sat_mode = ~sat_mode;
      cmp_val = 8'($urandom_range(0, 7));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
